ppu_vram_port: RTL and testbench

//  CPU-side PPUADDR($2006)/PPUDATA($2007) engine feeding the PPU VRAM block's cfg port.

---
 rtl/ppu_vram_port.sv | 154 +++++++++++++++
 tb/tb_ppu_vram_port.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_port.sv
// CPU-side PPUADDR/PPUDATA engine: owns the VRAM address v and write toggle w,
// and sequences each PPUDATA access onto the VRAM block's cfg port.
module ppu_vram_port #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rst,
  input  logic        i_reg_req,
  input  logic [2:0]  i_reg_addr,
  input  logic        i_reg_we,
  input  logic [7:0]  i_reg_wdata,
  output logic [7:0]  o_reg_rdata,
  output logic        o_reg_ack,
  output logic        o_busy,
  input  logic        i_inc32,
  input  logic        i_w_clr,
  output logic [15:0] o_vram_addr,
  output logic        o_vram_we,
  output logic [7:0]  o_vram_wdata,
  input  logic [7:0]  i_vram_rdata,
  output logic        o_2007_visit,
  output logic [13:0] o_v_addr
);

  typedef enum logic [1:0] {IDLE, ACC, ACC_MIR, ACK} state_t;

  localparam int CW = (ACC_CYCLES > 2) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [13:0]   v_reg;
  logic          w_reg;
  logic [5:0]    hi_reg;
  logic [7:0]    buf_reg;
  logic [7:0]    res_reg;
  logic [7:0]    rdata_reg;
  logic          wr_reg;
  logic [7:0]    wdata_reg;

  logic        accept;
  logic        cnt_last;
  logic        pal;
  logic        v_bump;
  logic [13:0] v_step;

  assign accept   = (state_reg == IDLE) && i_reg_req;
  assign cnt_last = (cnt_reg == CNT_LAST);
  assign pal      = (v_reg[13:8] == 6'h3F);
  assign v_step   = i_inc32 ? 14'd32 : 14'd1;
  // v advances when the last access state of a $2007 transfer ends
  assign v_bump   = ((state_reg == ACC) && cnt_last && (wr_reg || !pal)) ||
                    ((state_reg == ACC_MIR) && cnt_last);

  always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
    if (i_cpu_rst) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_reg_req) state_next = (i_reg_addr == 3'd7) ? ACC : ACK;
      ACC:     if (cnt_last)  state_next = (!wr_reg && pal) ? ACC_MIR : ACK;
      ACC_MIR: if (cnt_last)  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_2007_visit = 1'b0;
    o_vram_addr  = 16'h0000;
    o_vram_we    = 1'b0;
    o_vram_wdata = 8'h00;
    o_reg_ack    = 1'b0;
    case (state_reg)
      ACC: begin
        o_2007_visit = 1'b1;
        o_vram_addr  = {2'b00, v_reg};
        o_vram_we    = wr_reg;
        o_vram_wdata = wr_reg ? wdata_reg : 8'h00;
      end
      ACC_MIR: begin
        o_2007_visit = 1'b1;
        o_vram_addr  = {2'b00, v_reg & 14'h2FFF};
      end
      ACK:     o_reg_ack = 1'b1;
      default: ;
    endcase
  end

  assign o_busy      = (state_reg != IDLE);
  assign o_reg_rdata = rdata_reg;
  assign o_v_addr    = v_reg;

  always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
    if (i_cpu_rst) begin
      cnt_reg   <= '0;
      v_reg     <= 14'h0000;
      w_reg     <= 1'b0;
      hi_reg    <= 6'h00;
      buf_reg   <= 8'h00;
      res_reg   <= 8'h00;
      rdata_reg <= 8'h00;
      wr_reg    <= 1'b0;
      wdata_reg <= 8'h00;
    end else begin
      if (state_next != state_reg)
        cnt_reg <= '0;
      else if ((state_reg == ACC) || (state_reg == ACC_MIR))
        cnt_reg <= cnt_reg + CW'(1);

      // a coincident w clear wins, so the write is treated as a first write
      if (accept && (i_reg_addr == 3'd6) && i_reg_we) begin
        if (w_reg && !i_w_clr) begin
          v_reg <= {hi_reg, i_reg_wdata};
          w_reg <= 1'b0;
        end else begin
          hi_reg <= i_reg_wdata[5:0];
          w_reg  <= 1'b1;
        end
      end else if (i_w_clr) begin
        w_reg <= 1'b0;
      end

      if (accept) begin
        wr_reg    <= i_reg_we;
        wdata_reg <= i_reg_wdata;
        if (i_reg_addr != 3'd7) rdata_reg <= 8'h00;
      end

      if ((state_reg == ACC) && cnt_last) begin
        if (wr_reg) begin
          rdata_reg <= 8'h00;
        end else if (pal) begin
          res_reg <= i_vram_rdata;
        end else begin
          rdata_reg <= buf_reg;
          buf_reg   <= i_vram_rdata;
        end
      end

      // palette data goes out directly; the underlying nametable byte refills the buffer
      if ((state_reg == ACC_MIR) && cnt_last) begin
        buf_reg   <= i_vram_rdata;
        rdata_reg <= res_reg;
      end

      if (v_bump) v_reg <= v_reg + v_step;
    end
  end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed bench for ppu_vram_port: a queue scoreboard of expected ack data and
// latency, plus a byte-array VRAM model behind the cfg port.
module tb_ppu_vram_port;

  localparam int ACC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic        we = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        inc32 = 1'b0;
  logic        w_clr = 1'b0;
  logic [7:0]  rdata;
  logic        ack;
  logic        busy;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        visit;
  logic [13:0] v_addr;

  logic [7:0] mem [0:16383];

  typedef struct {
    logic [7:0] rdata;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  ppu_vram_port #(.ACC_CYCLES(ACC)) dut (
    .i_cpu_clk(clk),
    .i_cpu_rst(rst),
    .i_reg_req(req),
    .i_reg_addr(addr),
    .i_reg_we(we),
    .i_reg_wdata(wdata),
    .o_reg_rdata(rdata),
    .o_reg_ack(ack),
    .o_busy(busy),
    .i_inc32(inc32),
    .i_w_clr(w_clr),
    .o_vram_addr(vram_addr),
    .o_vram_we(vram_we),
    .o_vram_wdata(vram_wdata),
    .i_vram_rdata(vram_rdata),
    .o_2007_visit(visit),
    .o_v_addr(v_addr)
  );

  always #5 clk = ~clk;

  assign vram_rdata = mem[vram_addr[13:0]];
  always @(posedge clk) if (vram_we) mem[vram_addr[13:0]] <= vram_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One register transaction; checks every visit cycle and the ack against the scoreboard.
  task automatic xact(input logic [2:0] a, input logic w, input logic [7:0] d,
                      input logic [7:0] exp_rd, input int visits,
                      input logic [15:0] addr1, input logic [15:0] addr2,
                      input logic clr, input logic inject);
    exp_t e;
    int   nvis;
    bit   done;
    e.rdata = exp_rd;
    e.lat   = visits + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; addr = a; we = w; wdata = d; w_clr = clr;
    @(posedge clk); #1;
    req = 1'b0; addr = 3'd0; we = 1'b0; wdata = 8'h00; w_clr = 1'b0;
    nvis = 0;
    done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (inject && k == 1) begin
        chk("busy_during_access", busy, 1'b1);
        req = 1'b1; addr = 3'd6; we = 1'b1; wdata = 8'h3F;
      end else if (inject && k == 2) begin
        req = 1'b0; addr = 3'd0; we = 1'b0; wdata = 8'h00;
      end
      if (visit) begin
        nvis++;
        chk("visit_addr", vram_addr, (nvis <= ACC) ? addr1 : addr2);
        chk("visit_we", vram_we, w && (nvis <= ACC));
        if (w) chk("visit_wdata", vram_wdata, d);
      end
      if (ack) begin
        e = sb.pop_front();
        chk("ack_latency", k, e.lat);
        chk("rdata", rdata, e.rdata);
        chk("visit_count", nvis, visits);
        $display("txn reg=%0d we=%0b wdata=%02h rdata=%02h lat=%0d v=%04h",
                 a, w, d, rdata, k, v_addr);
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("ack_timeout", done, 1'b1);
      void'(sb.pop_front());
    end
  endtask

  task automatic set_v(input logic [13:0] v);
    xact(3'd6, 1'b1, {2'b00, v[13:8]}, 8'h00, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    xact(3'd6, 1'b1, v[7:0], 8'h00, 0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h3F01] = 8'h2A;
    mem[14'h2F01] = 8'h77;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_visit", visit, 1'b0);
    chk("rst_v", v_addr, 14'h0000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_vram_addr", vram_addr, 16'h0000);
    chk("rst_vram_we", vram_we, 1'b0);
    chk("rst_vram_wdata", vram_wdata, 8'h00);
    rst = 1'b0;

    // $2006 pair
    set_v(14'h2108);
    chk("v_after_2006", v_addr, 14'h2108);

    // $2007 write with +1 increment
    xact(3'd7, 1'b1, 8'h55, 8'h00, ACC, 16'h2108, 16'h0, 1'b0, 1'b0);
    chk("v_after_write", v_addr, 14'h2109);

    // delayed read buffer
    set_v(14'h2108);
    xact(3'd7, 1'b0, 8'h00, 8'h00, ACC, 16'h2108, 16'h0, 1'b0, 1'b0);
    xact(3'd7, 1'b0, 8'h00, 8'h55, ACC, 16'h2109, 16'h0, 1'b0, 1'b0);
    chk("v_after_reads", v_addr, 14'h210A);

    // palette read with nametable refill
    set_v(14'h3F01);
    xact(3'd7, 1'b0, 8'h00, 8'h2A, 2*ACC, 16'h3F01, 16'h2F01, 1'b0, 1'b0);
    chk("v_after_pal", v_addr, 14'h3F02);
    set_v(14'h2000);
    xact(3'd7, 1'b0, 8'h00, 8'h77, ACC, 16'h2000, 16'h0, 1'b0, 1'b0);
    chk("v_after_refill", v_addr, 14'h2001);

    // +32 increment wraps past $3FFF
    set_v(14'h3FE0);
    inc32 = 1'b1;
    xact(3'd7, 1'b1, 8'h11, 8'h00, ACC, 16'h3FE0, 16'h0, 1'b0, 1'b0);
    inc32 = 1'b0;
    chk("v_wrap", v_addr, 14'h0000);

    // w clear coinciding with a $2006 write makes it a first write
    xact(3'd6, 1'b1, 8'h12, 8'h00, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    xact(3'd6, 1'b1, 8'h05, 8'h00, 0, 16'h0, 16'h0, 1'b1, 1'b0);
    xact(3'd6, 1'b1, 8'h34, 8'h00, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("v_after_wclr", v_addr, 14'h0534);

    // $2006 write offered while busy must be dropped
    xact(3'd7, 1'b0, 8'h00, 8'h00, ACC, 16'h0534, 16'h0, 1'b0, 1'b1);
    chk("v_after_ignored", v_addr, 14'h0535);
    set_v(14'h0100);
    chk("v_after_ignored_pair", v_addr, 14'h0100);

    // unused register index
    xact(3'd3, 1'b1, 8'hAA, 8'h00, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("v_after_noop", v_addr, 14'h0100);

    // reset mid-access: buffer loaded, w set, then abort a write
    set_v(14'h2108);
    xact(3'd7, 1'b0, 8'h00, 8'h00, ACC, 16'h2108, 16'h0, 1'b0, 1'b0);
    xact(3'd6, 1'b1, 8'h3F, 8'h00, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; addr = 3'd7; we = 1'b1; wdata = 8'h99;
    @(posedge clk); #1;
    req = 1'b0; addr = 3'd0; we = 1'b0; wdata = 8'h00;
    chk("pre_rst_visit", visit, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_visit", visit, 1'b0);
    chk("mid_rst_we", vram_we, 1'b0);
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_v", v_addr, 14'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    set_v(14'h2109);
    chk("v_after_rst_pair", v_addr, 14'h2109);
    xact(3'd7, 1'b0, 8'h00, 8'h00, ACC, 16'h2109, 16'h0, 1'b0, 1'b0);
    xact(3'd7, 1'b0, 8'h00, 8'h00, ACC, 16'h210A, 16'h0, 1'b0, 1'b0);
    chk("v_final", v_addr, 14'h210B);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
